// File: rtl/unary_ops_decoder.sv
// Decoder for the unary-operator result bundle. It recovers vec and int from the
// redundant fields, cross-checks them, and counts bad bundles in a two-stage pipeline.
module unary_ops_decoder #(
    parameter int VEC_W = 8,
    parameter int INT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_bit_not,
    input  logic             in_log_not,
    input  logic [INT_W-1:0] in_minus,
    input  logic [VEC_W-1:0] in_plus,
    input  logic [INT_W-1:0] in_preinc,
    input  logic [INT_W-1:0] in_postdec,
    input  logic             in_red_and,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_vec,
    output logic [INT_W-1:0] out_int,
    output logic [4:0]       out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    // Valid/ready: a transfer happens on a rising edge where valid && ready.
    // A producer holds valid and its data until the transfer. Each stage is ready
    // when it is empty or when the stage after it is ready.
    logic             s1_valid_q;
    logic [VEC_W-1:0] s1_bit_not_q;
    logic             s1_log_not_q;
    logic [INT_W-1:0] s1_minus_q;
    logic [VEC_W-1:0] s1_plus_q;
    logic [INT_W-1:0] s1_preinc_q;
    logic [INT_W-1:0] s1_postdec_q;
    logic             s1_red_and_q;

    logic             s2_valid_q;
    logic [VEC_W-1:0] s2_vec_q;
    logic [INT_W-1:0] s2_int_q;
    logic [4:0]       s2_err_q;
    logic [CNT_W-1:0] err_count_q;

    logic             rdy1;
    logic             rdy2;
    logic [VEC_W-1:0] vec_d;
    logic [INT_W-1:0] int_d;
    logic [INT_W-1:0] int_inc;
    logic [4:0]       err_d;
    logic             cnt_inc;
    logic [CNT_W-1:0] err_count_d;

    assign rdy2     = !s2_valid_q || out_ready;
    assign rdy1     = !s1_valid_q || rdy2;
    assign in_ready = rdy1;

    // Negation and increment wrap modulo 2^INT_W, so -MIN and MAX+1 are legal.
    always_comb begin
        vec_d    = ~s1_bit_not_q;
        int_d    = '0 - s1_minus_q;
        int_inc  = int_d + INT_W'(1);
        err_d    = '0;
        err_d[0] = (s1_plus_q != vec_d);
        err_d[1] = (s1_log_not_q != !vec_d[0]);
        err_d[2] = (s1_preinc_q != int_inc);
        err_d[3] = (s1_postdec_q != int_inc);
        err_d[4] = (s1_red_and_q != &vec_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_bit_not_q <= '0;
            s1_log_not_q <= 1'b0;
            s1_minus_q   <= '0;
            s1_plus_q    <= '0;
            s1_preinc_q  <= '0;
            s1_postdec_q <= '0;
            s1_red_and_q <= 1'b0;
        end else if (rdy1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_bit_not_q <= in_bit_not;
                s1_log_not_q <= in_log_not;
                s1_minus_q   <= in_minus;
                s1_plus_q    <= in_plus;
                s1_preinc_q  <= in_preinc;
                s1_postdec_q <= in_postdec;
                s1_red_and_q <= in_red_and;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_vec_q   <= '0;
            s2_int_q   <= '0;
            s2_err_q   <= '0;
        end else if (rdy2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_vec_q <= vec_d;
                s2_int_q <= int_d;
                s2_err_q <= err_d;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    assign cnt_inc = s2_valid_q && out_ready && (s2_err_q != 5'd0);

    always_comb begin
        err_count_d = err_count_q;
        if (clr_count) begin
            err_count_d = '0;
        end else if (cnt_inc && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_vec   = s2_vec_q;
    assign out_int   = s2_int_q;
    assign out_err   = s2_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_unary_ops_decoder.sv
// Directed bench for unary_ops_decoder. A second instance with a 2-bit counter
// exercises saturation.
module tb_unary_ops_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_bit_not;
    logic        in_log_not;
    logic [31:0] in_minus;
    logic [7:0]  in_plus;
    logic [31:0] in_preinc;
    logic [31:0] in_postdec;
    logic        in_red_and;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_vec;
    logic [31:0] out_int;
    logic [4:0]  out_err;
    logic [15:0] err_count;
    logic        clr_count;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [7:0]  out_vec_s;
    logic [31:0] out_int_s;
    logic [4:0]  out_err_s;
    logic [1:0]  err_count_s;

    int total;
    int bad;
    logic [39:0] exp_q[$];

    unary_ops_decoder #(.VEC_W(8), .INT_W(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bit_not(in_bit_not), .in_log_not(in_log_not), .in_minus(in_minus),
        .in_plus(in_plus), .in_preinc(in_preinc), .in_postdec(in_postdec),
        .in_red_and(in_red_and), .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_int(out_int), .out_err(out_err),
        .err_count(err_count), .clr_count(clr_count)
    );

    unary_ops_decoder #(.VEC_W(8), .INT_W(32), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_bit_not(in_bit_not), .in_log_not(in_log_not), .in_minus(in_minus),
        .in_plus(in_plus), .in_preinc(in_preinc), .in_postdec(in_postdec),
        .in_red_and(in_red_and), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_vec(out_vec_s), .out_int(out_int_s), .out_err(out_err_s),
        .err_count(err_count_s), .clr_count(clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_bundle(input logic [7:0] bn, input logic ln, input logic [31:0] mn,
                                input logic [7:0] pl, input logic [31:0] pi,
                                input logic [31:0] pd, input logic ra);
        in_bit_not = bn;
        in_log_not = ln;
        in_minus   = mn;
        in_plus    = pl;
        in_preinc  = pi;
        in_postdec = pd;
        in_red_and = ra;
    endtask

    task automatic drive_encoded(input logic [7:0] v, input logic [31:0] i);
        drive_bundle(~v, ~v[0], 32'd0 - i, v, i + 32'd1, i + 32'd1, &v);
    endtask

    // Sends one bundle into an empty pipeline and returns at the negedge after the
    // result reaches S2; with out_ready high it is accepted at the next posedge.
    task automatic run_one(input logic [7:0] bn, input logic ln, input logic [31:0] mn,
                           input logic [7:0] pl, input logic [31:0] pi,
                           input logic [31:0] pd, input logic ra);
        @(posedge clk); #1;
        drive_bundle(bn, ln, mn, pl, pi, pd, ra);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
        drive_bundle(8'h00, 1'b0, 32'h0, 8'h00, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if ({out_vec, out_int, out_err} !== 45'd0) begin bad++; $display("FAIL reset_out_data got=%h/%h/%b want=0", out_vec, out_int, out_err); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_decode_ok();
        run_one(8'h5A, 1'b0, 32'hFFFF_FFFB, 8'hA5, 32'd6, 32'd6, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL case1_valid got=%b want=1", out_valid); end
        total++; if (out_vec !== 8'hA5) begin bad++; $display("FAIL case1_vec got=%h want=a5", out_vec); end
        total++; if (out_int !== 32'd5) begin bad++; $display("FAIL case1_int got=%h want=5", out_int); end
        total++; if (out_err !== 5'b00000) begin bad++; $display("FAIL case1_err got=%b want=00000", out_err); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL case1_count got=%0d want=0", err_count); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL case1_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_wrap();
        run_one(8'h00, 1'b0, 32'h8000_0001, 8'hFF, 32'h8000_0000, 32'h8000_0000, 1'b1);
        total++; if (out_vec !== 8'hFF) begin bad++; $display("FAIL max_vec got=%h want=ff", out_vec); end
        total++; if (out_int !== 32'h7FFF_FFFF) begin bad++; $display("FAIL max_int got=%h want=7fffffff", out_int); end
        total++; if (out_err !== 5'b00000) begin bad++; $display("FAIL max_err got=%b want=00000", out_err); end
        run_one(8'hFF, 1'b1, 32'h8000_0000, 8'h00, 32'h8000_0001, 32'h8000_0001, 1'b0);
        total++; if (out_int !== 32'h8000_0000) begin bad++; $display("FAIL min_int got=%h want=80000000", out_int); end
        total++; if (out_err !== 5'b00000) begin bad++; $display("FAIL min_err got=%b want=00000", out_err); end
        @(negedge clk);
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL wrap_count got=%0d want=0", err_count); end
    endtask

    task automatic test_errors();
        run_one(8'h5A, 1'b0, 32'hFFFF_FFFB, 8'hA4, 32'd6, 32'd6, 1'b1);
        total++; if (out_err !== 5'b10001) begin bad++; $display("FAIL err_plus_red got=%b want=10001", out_err); end
        @(negedge clk);
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL err_count1 got=%0d want=1", err_count); end
        run_one(8'h5A, 1'b1, 32'hFFFF_FFFB, 8'hA5, 32'd7, 32'd0, 1'b0);
        total++; if (out_err !== 5'b01110) begin bad++; $display("FAIL err_ln_pre_post got=%b want=01110", out_err); end
        @(negedge clk);
        total++; if (err_count !== 16'd2) begin bad++; $display("FAIL err_count2 got=%0d want=2", err_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vecs [4];
        logic [31:0] ints [4];
        logic [39:0] exp_v;
        int idx;
        int got;
        int acc_before_stall;
        logic in_acc;
        logic out_acc;
        vecs = '{8'h3C, 8'h01, 8'hF0, 8'h7E};
        ints = '{32'd1000, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678};
        exp_q.delete();
        idx = 0; got = 0; acc_before_stall = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 3);
            in_valid  = (idx < 4);
            if (idx < 4) drive_encoded(vecs[idx], ints[idx]);
            @(negedge clk);
            in_acc  = in_valid && in_ready;
            out_acc = out_valid && out_ready;
            if (c == 2) begin
                acc_before_stall = idx;
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready got=%b want=0", in_ready); end
            end
            if (in_acc) begin
                exp_q.push_back({vecs[idx], ints[idx]});
                idx++;
            end
            if (out_acc) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra got=%h/%h want=none", out_vec, out_int);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_vec, out_int} !== exp_v || out_err !== 5'd0) begin
                        bad++; $display("FAIL b2b_data got=%h/%h/%b want=%h/%h/00000", out_vec, out_int, out_err, exp_v[39:32], exp_v[31:0]);
                    end
                end
                got++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (acc_before_stall !== 2) begin bad++; $display("FAIL b2b_accepted_before_stall got=%0d want=2", acc_before_stall); end
        total++; if (got !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got); end
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_saturate();
        @(posedge clk); #1;
        clr_count = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            run_one(8'h5A, 1'b0, 32'hFFFF_FFFB, 8'hA4, 32'd6, 32'd6, 1'b1);
            @(negedge clk);
            total++; if (err_count_s !== ((k > 3) ? 2'd3 : 2'(k))) begin bad++; $display("FAIL sat_count%0d got=%0d want=%0d", k, err_count_s, (k > 3) ? 3 : k); end
            total++; if (err_count !== 16'(k)) begin bad++; $display("FAIL wide_count%0d got=%0d want=%0d", k, err_count, k); end
        end
        run_one(8'h5A, 1'b0, 32'hFFFF_FFFB, 8'hA4, 32'd6, 32'd6, 1'b1);
        clr_count = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        @(negedge clk);
        total++; if (err_count_s !== 2'd0) begin bad++; $display("FAIL sat_clear got=%0d want=0", err_count_s); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL wide_clear got=%0d want=0", err_count); end
    endtask

    task automatic test_reset_midstream();
        int seen;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            drive_encoded(8'h99 + 8'(k), 32'd77 + 32'(k));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_full got=%b want=1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_clear got=%b want=0", out_valid); end
        total++; if ({out_vec, out_int} !== 40'd0) begin bad++; $display("FAIL mid_data_clear got=%h/%h want=0", out_vec, out_int); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", seen); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_decode_ok();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_saturate();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
